// File: rtl/ioctl_upload_reader.sv
// rtl/ioctl_upload_reader.sv - services HPS upload reads from core memory and raises save requests
module ioctl_upload_reader #(
    parameter int          ADDR_W  = 13,
    parameter int          SIZE    = 8192,
    parameter logic [7:0]  INDEX   = 8'h01,
    parameter logic [7:0]  FILL    = 8'hFF,
    parameter int          TIMEOUT = 255
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              save_trigger,
    input  logic              mem_dirty_set,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              ioctl_upload_req,
    output logic [7:0]        ioctl_upload_index,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              dirty,
    output logic              busy
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [24:0] SIZE_A   = 25'(SIZE);
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

    state_t              state_q;
    logic [7:0]          cnt_q;
    logic [7:0]          din_q;
    logic                wait_q;
    logic                req_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                dirty_q;
    logic                dirty_d;
    logic                upreq_q;
    logic                trig_q;
    logic                active_q;
    logic                active;

    assign active = ioctl_upload && (ioctl_index == INDEX);

    // Read FSM: accept a read in IDLE, hold the memory request in WAIT until ack, timeout or abort
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            din_q   <= FILL;
            wait_q  <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ioctl_rd && active) begin
                        if (ioctl_addr >= SIZE_A) begin
                            // out-of-range bytes are answered at once without touching memory
                            din_q <= FILL;
                        end else begin
                            addr_q  <= ioctl_addr[ADDR_W-1:0];
                            req_q   <= 1'b1;
                            wait_q  <= 1'b1;
                            cnt_q   <= 8'd0;
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!active) begin
                        // upload ended under us: drop the request, keep the last byte, ignore any ack
                        req_q   <= 1'b0;
                        wait_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (mem_ack) begin
                        din_q   <= mem_rdata;
                        req_q   <= 1'b0;
                        wait_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (cnt_q == TMO_LAST) begin
                        din_q   <= FILL;
                        req_q   <= 1'b0;
                        wait_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Dirty next state: upload end clears, a write in the same cycle keeps it set
    always_comb begin
        dirty_d = dirty_q;
        if (active_q && !active) begin
            dirty_d = 1'b0;
        end
        if (mem_dirty_set) begin
            dirty_d = 1'b1;
        end
    end

    // Edge detectors, dirty flag and the single-cycle upload request pulse
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            trig_q   <= 1'b0;
            dirty_q  <= 1'b0;
            upreq_q  <= 1'b0;
        end else begin
            active_q <= active;
            trig_q   <= save_trigger;
            dirty_q  <= dirty_d;
            upreq_q  <= save_trigger && !trig_q && dirty_q && !ioctl_upload;
        end
    end

    assign ioctl_din          = din_q;
    assign ioctl_wait         = wait_q;
    assign ioctl_upload_req   = upreq_q;
    assign ioctl_upload_index = INDEX;
    assign mem_req            = req_q;
    assign mem_addr           = addr_q;
    assign dirty              = dirty_q;
    assign busy               = (state_q == S_WAIT);

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// tb/tb_ioctl_upload_reader.sv - self-checking bench for ioctl_upload_reader
module tb_ioctl_upload_reader;

    localparam int SIZE    = 8192;
    localparam int TIMEOUT = 255;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        save_trigger;
    logic        mem_dirty_set;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        ioctl_upload_req;
    logic [7:0]  ioctl_upload_index;
    logic        mem_req;
    logic [12:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        dirty;
    logic        busy;

    int tests  = 0;
    int failed = 0;

    logic [7:0] mem_model [SIZE];
    logic [7:0] last_din;

    ioctl_upload_reader dut (
        .clk_sys            (clk_sys),
        .reset_n            (reset_n),
        .save_trigger       (save_trigger),
        .mem_dirty_set      (mem_dirty_set),
        .ioctl_upload       (ioctl_upload),
        .ioctl_index        (ioctl_index),
        .ioctl_rd           (ioctl_rd),
        .ioctl_addr         (ioctl_addr),
        .ioctl_din          (ioctl_din),
        .ioctl_wait         (ioctl_wait),
        .ioctl_upload_req   (ioctl_upload_req),
        .ioctl_upload_index (ioctl_upload_index),
        .mem_req            (mem_req),
        .mem_addr           (mem_addr),
        .mem_ack            (mem_ack),
        .mem_rdata          (mem_rdata),
        .dirty              (dirty),
        .busy               (busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One hps_io read; the memory answers 'delay' cycles after the request is first seen
    task automatic do_read(input logic [24:0] addr, input int delay, input string tag);
        int         cycles;
        int         wait_low;
        logic [7:0] exp_din;
        @(negedge clk_sys);
        ioctl_rd   = 1'b1;
        ioctl_addr = addr;
        @(negedge clk_sys);
        ioctl_rd   = 1'b0;
        if (addr >= 25'(SIZE)) begin
            chk({tag, "_oor_din"}, 32'(ioctl_din), 32'hFF);
            chk({tag, "_oor_wait"}, 32'(ioctl_wait), 32'd0);
            chk({tag, "_oor_req"}, 32'(mem_req), 32'd0);
            last_din = 8'hFF;
        end else begin
            chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(addr[12:0]));
            cycles   = 0;
            wait_low = 0;
            while (mem_req === 1'b1 && cycles < 400) begin
                if (ioctl_wait !== 1'b1 || busy !== 1'b1) wait_low++;
                if (cycles == delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_model[addr[12:0]];
                end
                cycles++;
                @(negedge clk_sys);
                mem_ack   = 1'b0;
                mem_rdata = 8'($urandom);
            end
            exp_din = (delay < TIMEOUT) ? mem_model[addr[12:0]] : 8'hFF;
            chk({tag, "_req_cycles"}, 32'(cycles), (delay < TIMEOUT) ? 32'(delay + 1) : 32'(TIMEOUT));
            chk({tag, "_wait_held"}, 32'(wait_low), 32'd0);
            chk({tag, "_din"}, 32'(ioctl_din), 32'(exp_din));
            chk({tag, "_wait_done"}, 32'(ioctl_wait), 32'd0);
            chk({tag, "_busy_done"}, 32'(busy), 32'd0);
            last_din = exp_din;
        end
    endtask

    task automatic count_req(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk_sys);
            if (ioctl_upload_req === 1'b1) c++;
        end
    endtask

    initial begin
        int          pulses;
        logic [24:0] a;

        for (int i = 0; i < SIZE; i++) mem_model[i] = 8'($urandom);

        reset_n       = 1'b0;
        save_trigger  = 1'b0;
        mem_dirty_set = 1'b0;
        ioctl_upload  = 1'b0;
        ioctl_index   = 8'h01;
        ioctl_rd      = 1'b0;
        ioctl_addr    = '0;
        mem_ack       = 1'b0;
        mem_rdata     = 8'h00;
        last_din      = 8'hFF;

        repeat (3) @(negedge clk_sys);
        chk("rst_din", 32'(ioctl_din), 32'hFF);
        chk("rst_wait", 32'(ioctl_wait), 32'd0);
        chk("rst_upreq", 32'(ioctl_upload_req), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_dirty", 32'(dirty), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("upload_index", 32'(ioctl_upload_index), 32'h01);
        reset_n = 1'b1;

        // directed reads
        @(negedge clk_sys);
        ioctl_upload = 1'b1;
        do_read(25'h0010, 3, "inrange");
        do_read(25'h2000, 0, "oor");
        chk("oor_req_stays_low", 32'(mem_req), 32'd0);
        do_read(25'h0005, 0, "min_latency");
        do_read(25'h1FFF, 254, "ack_at_limit");
        do_read(25'h0100, 1000, "timeout");
        do_read(25'h0000, 0, "after_timeout");

        // randomized reads against the transaction model
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) a = 25'($urandom_range(SIZE, 32'h1FFFFFF));
            else a = 25'($urandom_range(0, SIZE - 1));
            do_read(a, int'($urandom_range(0, 6)), "rand");
        end

        // index mismatch: read ignored
        @(negedge clk_sys);
        ioctl_index = 8'h02;
        ioctl_rd    = 1'b1;
        ioctl_addr  = 25'h0010;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        chk("idx_mismatch_req", 32'(mem_req), 32'd0);
        chk("idx_mismatch_wait", 32'(ioctl_wait), 32'd0);
        ioctl_index = 8'h01;

        // abort during WAIT, with a late ack in the same cycle
        @(negedge clk_sys);
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'h0123;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        chk("abort_req_before", 32'(mem_req), 32'd1);
        @(negedge clk_sys);
        ioctl_upload = 1'b0;
        mem_ack      = 1'b1;
        mem_rdata    = ~last_din;
        @(negedge clk_sys);
        mem_ack = 1'b0;
        chk("abort_req", 32'(mem_req), 32'd0);
        chk("abort_wait", 32'(ioctl_wait), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_din", 32'(ioctl_din), 32'(last_din));

        // dirty and upload request
        @(negedge clk_sys);
        mem_dirty_set = 1'b1;
        @(negedge clk_sys);
        mem_dirty_set = 1'b0;
        chk("dirty_set", 32'(dirty), 32'd1);
        save_trigger = 1'b1;
        count_req(8, pulses);
        chk("upreq_one_pulse", 32'(pulses), 32'd1);
        save_trigger = 1'b0;
        @(negedge clk_sys);
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        save_trigger = 1'b1;
        count_req(6, pulses);
        chk("upreq_during_upload", 32'(pulses), 32'd0);
        save_trigger = 1'b0;
        ioctl_upload = 1'b0;
        @(negedge clk_sys);
        chk("dirty_clear_on_end", 32'(dirty), 32'd0);
        save_trigger = 1'b1;
        count_req(6, pulses);
        chk("upreq_when_clean", 32'(pulses), 32'd0);
        save_trigger = 1'b0;
        ioctl_upload = 1'b1;
        repeat (2) @(negedge clk_sys);
        ioctl_upload  = 1'b0;
        mem_dirty_set = 1'b1;
        @(negedge clk_sys);
        mem_dirty_set = 1'b0;
        chk("dirty_set_wins", 32'(dirty), 32'd1);

        // asynchronous reset in the middle of a WAIT
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'h0042;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        chk("areset_in_wait", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_wait", 32'(ioctl_wait), 32'd0);
        chk("areset_mem_req", 32'(mem_req), 32'd0);
        chk("areset_din", 32'(ioctl_din), 32'hFF);
        chk("areset_dirty", 32'(dirty), 32'd0);
        chk("areset_busy", 32'(busy), 32'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        do_read(25'h0007, 2, "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
